// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the AXI4 read-channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [3:0] AXI_ARCACHE_DEF = 4'b0011;
  localparam logic [2:0] AXI_ARPROT_DEF  = 3'b000;

  // Index width for a requester count; never below 1 so vectors stay legal.
  function automatic int clog2_req(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address/data channel bundle between the arbiter and one slave.
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) ();
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2_req(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic [IW:0] cand;
    cand    = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && req[cand[IW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    gnt_oh = N'(any) << gnt_idx;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI4 read slave among NUM_REQ requesters,
// one transaction in flight, with routed R beats and a saturating error-beat count.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int ID_WIDTH      = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][7:0]             req_len,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [DATA_WIDTH-1:0]               resp_data,
  output logic                                resp_last,
  output logic                                resp_err,
  axi_rd_arbiter_if.master                    m_axi,
  output logic [ERR_CNT_WIDTH-1:0]            err_count,
  output logic                                busy
);

  localparam int IW = clog2_req(NUM_REQ);

  arb_state_e            state, state_nxt;
  logic [IW-1:0]         rr_ptr, grant, pick_idx;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q, beat_cnt;
  logic                  accept, ar_fire, r_fire, beat_err;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign accept  = (state == IDLE) && pick_any;
  assign ar_fire = (state == ADDR) && m_axi.arready;
  assign r_fire  = (state == DATA) && m_axi.rvalid && resp_ready[grant];

  // Any protocol oddity on a beat counts once, however many causes coincide.
  assign beat_err = (m_axi.rresp != AXI_RESP_OKAY) ||
                    (m_axi.rid != ID_WIDTH'(grant)) ||
                    (m_axi.rlast != (beat_cnt == 8'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = ADDR;
      ADDR:    if (m_axi.arready) state_nxt = DATA;
      DATA:    if (r_fire && m_axi.rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    resp_valid    = '0;
    resp_data     = '0;
    resp_last     = 1'b0;
    resp_err      = 1'b0;
    unique case (state)
      IDLE: req_ready = pick_oh;
      ADDR: m_axi.arvalid = 1'b1;
      DATA: begin
        m_axi.rready = resp_ready[grant];
        resp_valid   = NUM_REQ'(m_axi.rvalid) << grant;
        resp_data    = m_axi.rdata;
        resp_last    = m_axi.rlast;
        resp_err     = (m_axi.rresp != AXI_RESP_OKAY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        grant    <= pick_idx;
        addr_q   <= req_addr[pick_idx];
        len_q    <= req_len[pick_idx];
        beat_cnt <= req_len[pick_idx];
      end
      if (r_fire) begin
        if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
        if (beat_err && !(&err_count)) err_count <= err_count + ERR_CNT_WIDTH'(1);
        if (m_axi.rlast)
          rr_ptr <= (grant == IW'(NUM_REQ-1)) ? '0 : grant + IW'(1);
      end
    end
  end

  assign m_axi.arid    = ID_WIDTH'(grant);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_ARCACHE_DEF;
  assign m_axi.arprot  = AXI_ARPROT_DEF;

  assign busy = (state != IDLE);

  logic unused_ok;
  assign unused_ok = ar_fire;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays the AXI slave cycle by cycle.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int N = 2, DW = 32, AW = 16, IDW = 8, EW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][7:0]    req_len;
  logic [DW-1:0]        resp_data;
  logic                 resp_last, resp_err, busy;
  logic [EW-1:0]        err_count;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) axi ();

  axi_rd_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .m_axi      (axi),
    .err_count  (err_count),
    .busy       (busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with requests already driven; leaves at a negedge in DATA.
  task automatic grant_ar(input int g, input logic [AW-1:0] addr, input logic [7:0] len,
                          input int ar_wait, input bit drop);
    #1;
    chk("req_ready_grant", req_ready, 32'(N'(1) << g));
    chk("busy_idle", busy, 0);
    @(negedge clk);
    if (drop) req_valid = '0;
    #1;
    chk("arvalid", axi.arvalid, 1);
    chk("arid", axi.arid, g);
    chk("araddr", axi.araddr, addr);
    chk("arlen", axi.arlen, len);
    chk("arsize", axi.arsize, 2);
    chk("arburst", axi.arburst, 1);
    chk("arcache", axi.arcache, 4'b0011);
    chk("req_ready_addr", req_ready, 0);
    chk("busy_addr", busy, 1);
    repeat (ar_wait) begin
      @(negedge clk); #1;
      chk("arvalid_hold", axi.arvalid, 1);
      chk("araddr_hold", axi.araddr, addr);
    end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    #1;
    chk("arvalid_drop", axi.arvalid, 0);
  endtask

  task automatic beats(input int g, input int n, input int last_at, input int err_at,
                       input logic [1:0] err_resp, input int badid_at, input int stall_at,
                       input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = base + 32'(b);
      axi.rlast  = (b == last_at);
      axi.rresp  = (b == err_at) ? err_resp : 2'b00;
      axi.rid    = (b == badid_at) ? 8'h5A : IDW'(g);
      if (b == stall_at) begin
        resp_ready[g] = 1'b0;
        repeat (5) begin
          #1;
          chk("stall_rready", axi.rready, 0);
          chk("stall_data", resp_data, base + 32'(b));
          chk("stall_valid", resp_valid, 32'(N'(1) << g));
          @(negedge clk);
        end
        resp_ready[g] = 1'b1;
      end
      #1;
      chk("beat_valid", resp_valid, 32'(N'(1) << g));
      chk("beat_data", resp_data, base + 32'(b));
      chk("beat_last", resp_last, (b == last_at));
      chk("beat_err", resp_err, (b == err_at));
      chk("beat_rready", axi.rready, 1);
      chk("beat_req_ready", req_ready, 0);
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0; resp_ready = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rresp = 2'b00; axi.rdata = '0; axi.rid = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err", err_count, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arid", axi.arid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = '1;
    @(negedge clk);

    // single requester 0, 4-beat burst, requester drops valid after accept
    req_valid = 2'b01; req_addr[0] = 16'h0100; req_len[0] = 8'd3;
    grant_ar(0, 16'h0100, 8'd3, 1, 1);
    beats(0, 4, 3, -1, 2'b00, -1, -1, 32'hA0);
    #1;
    chk("t1_busy_after_last", busy, 0);
    chk("t1_err", err_count, 0);

    // both requesters continuously valid: rr_ptr is 1 here, so 1,0,1,0...
    req_valid = 2'b11;
    req_addr[0] = 16'h0200; req_addr[1] = 16'h0300;
    req_len[0] = 8'd0; req_len[1] = 8'd0;
    for (int i = 0; i < 8; i++) begin
      grant_ar((i + 1) % 2, ((i + 1) % 2) ? 16'h0300 : 16'h0200, 8'd0, 0, 0);
      beats((i + 1) % 2, 1, 0, -1, 2'b00, -1, -1, 32'h100 * i);
    end
    req_valid = '0;

    // requester 1 stalls before beat 2
    req_valid = 2'b10; req_addr[1] = 16'h0400; req_len[1] = 8'd3;
    grant_ar(1, 16'h0400, 8'd3, 0, 1);
    beats(1, 4, 3, -1, 2'b00, -1, 2, 32'hB0);
    #1;
    chk("t3_err", err_count, 0);

    // SLVERR on beat 2 of 4, then DECERR on beat 4 of a later burst
    req_valid = 2'b01; req_addr[0] = 16'h0500; req_len[0] = 8'd3;
    grant_ar(0, 16'h0500, 8'd3, 0, 1);
    beats(0, 4, 3, 1, 2'b10, -1, -1, 32'hC0);
    #1;
    chk("t4_err_slverr", err_count, 1);
    req_valid = 2'b01;
    grant_ar(0, 16'h0500, 8'd3, 0, 1);
    beats(0, 4, 3, 3, 2'b11, -1, -1, 32'hC8);
    #1;
    chk("t4_err_decerr", err_count, 2);

    // async reset mid-burst; rr_ptr is 1 before it, so a grant to 0 shows the reset
    req_valid = 2'b10; req_addr[1] = 16'h0600; req_len[1] = 8'd3;
    grant_ar(1, 16'h0600, 8'd3, 0, 1);
    beats(1, 1, -1, -1, 2'b00, -1, -1, 32'hD0);
    axi.rvalid = 1'b1; axi.rdata = 32'hDEAD; axi.rid = 8'd1;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_rready", axi.rready, 0);
    chk("t5_arvalid", axi.arvalid, 0);
    chk("t5_resp_data", resp_data, 0);
    chk("t5_err", err_count, 0);
    axi.rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_addr[0] = 16'h0700; req_addr[1] = 16'h0800;
    req_len[0] = 8'd0; req_len[1] = 8'd0;
    grant_ar(0, 16'h0700, 8'd0, 0, 1);
    beats(0, 1, 0, -1, 2'b00, -1, -1, 32'hE0);

    // rlast after 2 beats of a len-3 burst
    req_valid = 2'b10; req_addr[1] = 16'h0900; req_len[1] = 8'd3;
    grant_ar(1, 16'h0900, 8'd3, 0, 1);
    beats(1, 2, 1, -1, 2'b00, -1, -1, 32'hF0);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_err_early_last", err_count, 1);
    req_valid = 2'b01; req_addr[0] = 16'h0A00; req_len[0] = 8'd1;
    grant_ar(0, 16'h0A00, 8'd1, 0, 1);
    beats(0, 2, 1, -1, 2'b00, -1, -1, 32'h110);
    #1;
    chk("t6_err_after_normal", err_count, 1);

    // SLVERR and wrong rid on the same beat count once; wrong rid alone counts
    req_valid = 2'b10; req_addr[1] = 16'h0B00; req_len[1] = 8'd1;
    grant_ar(1, 16'h0B00, 8'd1, 0, 1);
    beats(1, 2, 1, 0, 2'b10, 0, -1, 32'h120);
    #1;
    chk("t7_err_once", err_count, 2);
    req_valid = 2'b01; req_addr[0] = 16'h0C00; req_len[0] = 8'd0;
    grant_ar(0, 16'h0C00, 8'd0, 0, 1);
    beats(0, 1, 0, -1, 2'b00, 0, -1, 32'h130);
    #1;
    chk("t7_err_badid", err_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the AXI4 read channel (AR/R) of a single memory slave between NUM_REQ requesters, e.g. I-cache refill and D-cache refill in riscv-formal cache testbenches.
- Arbitration is round-robin with exactly one transaction outstanding.
- R beats are routed back to the granted requester, and beats with a non-OKAY rresp are flagged.
- A saturating count of error beats is kept for bench assertions.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, AXI data width in bits.
- ADDR_WIDTH, 16, AXI address width in bits.
- ID_WIDTH, 8, AXI ID width; must be >= clog2(NUM_REQ).
- ERR_CNT_WIDTH, 16, width of the error-beat counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester read request valid
- req_ready  out  NUM_REQ  per-requester request accepted
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; slice i belongs to requester i
- req_len  in  NUM_REQ*8  packed AXI burst lengths (beats-1)
- resp_valid  out  NUM_REQ  beat valid toward requester i
- resp_ready  in  NUM_REQ  requester i accepts beat
- resp_data  out  DATA_WIDTH  beat data, shared by all requesters and qualified by resp_valid
- resp_last  out  1  last beat of the burst
- resp_err  out  1  this beat had rresp != 2'b00
- m_axi_arid  out  ID_WIDTH  grant index, zero-extended
- m_axi_araddr  out  ADDR_WIDTH  latched address
- m_axi_arlen  out  8  latched length
- m_axi_arsize  out  3  constant clog2(DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arlock, m_axi_arcache, m_axi_arprot  out  1/4/3  constant 0 / 4'b0011 / 3'b000
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  slave accepts address
- m_axi_rid  in  ID_WIDTH  returned ID
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  read beat valid
- m_axi_rready  out  1  arbiter accepts beat
- err_count  out  ERR_CNT_WIDTH  saturating count of error beats
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, rr_ptr=0, grant=0, err_count=0.
  - All valid/ready outputs 0; m_axi_ar* payload 0.
  - Reset mid-burst abandons the transaction, with no drain; the bench also resets the slave.
- States:
  - IDLE: if any req_valid, choose the first requester at or after rr_ptr, cyclically. Pulse req_ready[g] combinationally in that cycle. Latch addr/len/g into registers. Next state ADDR. No requests: stay.
  - ADDR: m_axi_arvalid=1, payload stable from registers. On arready: ADDR->DATA, and arvalid drops the following cycle.
  - DATA:
    - m_axi_rready = resp_ready[g]; resp_valid[g] = m_axi_rvalid. All other resp_valid bits are 0. resp_data/resp_last pass through combinationally (zero added latency).
    - resp_err = (m_axi_rresp != 2'b00). Both SLVERR (2'b10) and DECERR (2'b11) count as errors.
    - On rvalid&&rready&&rlast: rr_ptr = (g+1) mod NUM_REQ, next IDLE.
- Latency:
  - Request accept to arvalid: 1 cycle.
  - Minimum turnaround: last beat to the next req_ready is 1 cycle, so there is no back-to-back grant in the same cycle as rlast.
- Beats arriving while not in DATA are not accepted (rready=0).
- Beats with m_axi_rid != latched grant: still routed to g, and the error counter increments (protocol error).
- Beat count: an internal counter is loaded with len and decremented per beat. On rlast with count != 0, or count==0 without rlast, err_count increments; the transition follows rlast only.
- err_count: +1 per error beat (rresp error, ID mismatch, or length mismatch), counted at most once per beat. Saturates at all-ones.
- Grant is never revoked: a requester dropping req_valid after acceptance has no effect.
- Requester index arithmetic is modulo NUM_REQ, including the wrap from NUM_REQ-1 to 0.

Decomposition:
- Package axi_arb_pkg:
  - state enum (IDLE/ADDR/DATA).
  - AXI constants: burst INCR=2'b01, RESP_OKAY=2'b00, default arcache.
  - function clog2_req.
- One sub-module, rr_pick: combinational round-robin selector (req vector, ptr -> one-hot grant + index).

Test Plan:
- Single requester 0, addr 0x0100, len 3, rresp all 00 -> arid=0, araddr=0x0100, arlen=3; 4 beats to requester 0, resp_last on the 4th; err_count=0; busy low 1 cycle after rlast.
- Both requesters valid continuously, len 0 -> grants alternate 0,1,0,1; arid follows the grant; no starvation over 8 transactions.
- Requester 1 holds resp_ready low for 5 cycles mid-burst -> m_axi_rready low for those cycles; data held; no beat dropped or duplicated.
- Slave returns rresp=2'b10 on beat 2 of 4 -> resp_err high on that beat only; err_count=1. rresp=2'b11 on a later burst -> err_count=2.
- rst_n asserted in DATA after 1 of 4 beats -> all outputs 0 immediately (async); after release, a new request is granted starting at requester 0.
- Slave asserts rlast after 2 beats of len 3 -> transaction ends; err_count increments by 1; next grant proceeds normally.
